trace_event_checker: RTL

- Hardware consumer of the CPU retirement-trace event stream; the compare-side counterpart of the trace writer.
- Accepts an expected-trace record stream from a loader (ROM/host) and buffers it.
- Compares it in order against live commit events from the 5-stage cpu: register writes, data-memory loads/stores, halt.
- Reports pass/fail, the first mismatch and event counts, so self-checking simulation and FPGA runs need no file I/O.

---
 rtl/trace_chk_pkg.sv | 34 +++
 rtl/trace_fifo.sv | 48 ++++
 rtl/trace_event_checker.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/trace_chk_pkg.sv
// Shared constants and types for the retirement-trace checker.
// Record kinds, error codes, checker states and the default-width record layout.
package trace_chk_pkg;

  localparam logic [1:0] KIND_REG   = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_HALT  = 2'd3;

  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_REG_MISMATCH  = 3'd1;
  localparam logic [2:0] ERR_MEM_MISMATCH  = 3'd2;
  localparam logic [2:0] ERR_REG_UNDERFLOW = 3'd3;
  localparam logic [2:0] ERR_MEM_UNDERFLOW = 3'd4;
  localparam logic [2:0] ERR_LEFTOVER      = 3'd5;
  localparam logic [2:0] ERR_NO_HALT       = 3'd6;
  localparam logic [2:0] ERR_RDWR          = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_e;

  localparam int REC_AW = 16;

  // Loader-side view of one expected record at the default width.
  typedef struct packed {
    logic [1:0]        kind;
    logic [REC_AW-1:0] addr;
    logic [REC_AW-1:0] data;
  } trace_rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for expected trace records.
// Push while full and pop while empty are ignored; pointers never move on them.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/trace_event_checker.sv
// Compares live CPU commit events against a preloaded expected trace.
// Reg and mem events are checked independently each RUN cycle; first error is latched.
module trace_event_checker
  import trace_chk_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          exp_valid,
  output logic          exp_ready,
  input  logic [1:0]    exp_kind,
  input  logic [AW-1:0] exp_addr,
  input  logic [AW-1:0] exp_data,
  input  logic          obs_reg_we,
  input  logic [3:0]    obs_reg_addr,
  input  logic [AW-1:0] obs_reg_data,
  input  logic          obs_mem_rd,
  input  logic          obs_mem_wr,
  input  logic [AW-1:0] obs_mem_addr,
  input  logic [AW-1:0] obs_mem_data,
  input  logic          obs_hlt,
  output logic          done,
  output logic          pass,
  output logic [2:0]    err_code,
  output logic [31:0]   err_cycle,
  output logic [AW-1:0] err_obs_data,
  output logic [15:0]   reg_cnt,
  output logic [15:0]   mem_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Reg records only need the 4-bit register number.
  typedef struct packed {
    logic [3:0]    addr;
    logic [AW-1:0] data;
  } reg_rec_t;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [AW-1:0] data;
  } mem_rec_t;

  state_e        state_q, state_d;
  logic          hlt_seen_q, hlt_seen_d;
  logic [31:0]   run_cyc_q, run_cyc_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [31:0]   err_cycle_q, err_cycle_d;
  logic [AW-1:0] err_obs_q, err_obs_d;
  logic [15:0]   reg_cnt_q, reg_cnt_d;
  logic [15:0]   mem_cnt_q, mem_cnt_d;

  reg_rec_t      reg_in, reg_head;
  mem_rec_t      mem_in, mem_head;
  logic          reg_full, reg_empty, mem_full, mem_empty;
  logic [CW-1:0] reg_count, mem_count;
  logic          accept, reg_push, mem_push, reg_pop, mem_pop;

  logic          is_run, reg_ev, mem_ev, mem_both, reg_match, mem_match;
  logic [1:0]    mem_kind_exp;
  logic [2:0]    ev_code, cyc_code;
  logic [AW-1:0] cyc_obs;
  logic          reg_left, mem_left;

  assign exp_ready = !reg_full && !mem_full && (state_q == ST_IDLE || state_q == ST_RUN);
  assign accept    = exp_valid && exp_ready;
  assign reg_push  = accept && (exp_kind == KIND_REG);
  assign mem_push  = accept && (exp_kind == KIND_LOAD || exp_kind == KIND_STORE);
  assign reg_in    = '{addr: exp_addr[3:0], data: exp_data};
  assign mem_in    = '{kind: exp_kind, addr: exp_addr, data: exp_data};

  trace_fifo #(.DEPTH(DEPTH), .W($bits(reg_rec_t))) u_reg_fifo (
    .clk(clk), .rst(rst), .push_i(reg_push), .pop_i(reg_pop), .din_i(reg_in),
    .dout_o(reg_head), .full_o(reg_full), .empty_o(reg_empty), .count_o(reg_count)
  );

  trace_fifo #(.DEPTH(DEPTH), .W($bits(mem_rec_t))) u_mem_fifo (
    .clk(clk), .rst(rst), .push_i(mem_push), .pop_i(mem_pop), .din_i(mem_in),
    .dout_o(mem_head), .full_o(mem_full), .empty_o(mem_empty), .count_o(mem_count)
  );

  // Per-cycle compare of FIFO heads against observed events.
  always_comb begin
    is_run       = (state_q == ST_RUN);
    reg_ev       = is_run && obs_reg_we;
    mem_ev       = is_run && (obs_mem_rd ^ obs_mem_wr);
    mem_both     = is_run && obs_mem_rd && obs_mem_wr;
    mem_kind_exp = obs_mem_rd ? KIND_LOAD : KIND_STORE;
    reg_match    = (reg_head.addr == obs_reg_addr) && (reg_head.data == obs_reg_data);
    mem_match    = (mem_head.kind == mem_kind_exp) && (mem_head.addr == obs_mem_addr) &&
                   (mem_head.data == obs_mem_data);
    reg_pop      = reg_ev && !reg_empty && reg_match;
    mem_pop      = mem_ev && !mem_empty && mem_match;

    ev_code = ERR_NONE;
    if (mem_both)                            ev_code = ERR_RDWR;
    else if (reg_ev && !reg_empty && !reg_match) ev_code = ERR_REG_MISMATCH;
    else if (reg_ev && reg_empty)            ev_code = ERR_REG_UNDERFLOW;
    else if (mem_ev && !mem_empty && !mem_match) ev_code = ERR_MEM_MISMATCH;
    else if (mem_ev && mem_empty)            ev_code = ERR_MEM_UNDERFLOW;

    reg_left = (reg_count != CW'(reg_pop));
    mem_left = (mem_count != CW'(mem_pop));

    cyc_code = ev_code;
    if (ev_code == ERR_NONE && is_run && obs_hlt) begin
      if (!hlt_seen_q)             cyc_code = ERR_NO_HALT;
      else if (reg_left || mem_left) cyc_code = ERR_LEFTOVER;
    end

    unique case (cyc_code)
      ERR_REG_MISMATCH, ERR_REG_UNDERFLOW:           cyc_obs = obs_reg_data;
      ERR_MEM_MISMATCH, ERR_MEM_UNDERFLOW, ERR_RDWR: cyc_obs = obs_mem_data;
      default:                                       cyc_obs = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hlt_seen_d  = hlt_seen_q || (accept && exp_kind == KIND_HALT);
    run_cyc_d   = run_cyc_q;
    err_code_d  = err_code_q;
    err_cycle_d = err_cycle_q;
    err_obs_d   = err_obs_q;
    reg_cnt_d   = reg_pop ? sat_inc16(reg_cnt_q) : reg_cnt_q;
    mem_cnt_d   = mem_pop ? sat_inc16(mem_cnt_q) : mem_cnt_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_RUN;
        run_cyc_d = '0;
      end
      ST_RUN: begin
        run_cyc_d = run_cyc_q + 32'd1;
        if (cyc_code != ERR_NONE) begin
          state_d     = ST_FAIL;
          err_code_d  = cyc_code;
          err_cycle_d = run_cyc_q;
          err_obs_d   = cyc_obs;
        end else if (obs_hlt) begin
          state_d = ST_PASS;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hlt_seen_q  <= 1'b0;
      run_cyc_q   <= '0;
      err_code_q  <= ERR_NONE;
      err_cycle_q <= '0;
      err_obs_q   <= '0;
      reg_cnt_q   <= '0;
      mem_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hlt_seen_q  <= hlt_seen_d;
      run_cyc_q   <= run_cyc_d;
      err_code_q  <= err_code_d;
      err_cycle_q <= err_cycle_d;
      err_obs_q   <= err_obs_d;
      reg_cnt_q   <= reg_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
    end
  end

  assign done         = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass         = (state_q == ST_PASS);
  assign err_code     = err_code_q;
  assign err_cycle    = err_cycle_q;
  assign err_obs_data = err_obs_q;
  assign reg_cnt      = reg_cnt_q;
  assign mem_cnt      = mem_cnt_q;

endmodule
